// File: rtl/gate_tester.sv
// gate_tester: sequences {a,b} = 00,01,10,11 into a 2-input combinational gate,
// samples its output after a settle window and reports a fail mask and pass/done.
module gate_tester #(
  parameter logic [3:0]  EXPECT_TT     = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  // State and output registers; the vector index doubles as the {a,b} drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic; outputs are computed here and registered above.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mask_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Counter saturates at its last value so it never exceeds SETTLE_CYCLES-1.
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (y_in != EXPECT_TT[idx_q]) begin
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          // pass uses the mask including this final sample.
          done_d  = 1'b1;
          pass_d  = (mask_d == 4'b0000);
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign vec_idx   = idx_q;
  assign fail_mask = mask_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: three instances (default params with selectable gate,
// OR-expectation, single-cycle settle) checked against a results scoreboard.
module tb_gate_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v, a_v, b_v, y_v, busy_v, done_v, pass_v;
  logic [3:0] mask_v [3];
  logic [1:0] idx_v  [3];
  int         mode;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    int         mode;
    logic [3:0] mask;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         cyc;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];

  always #5 clk = ~clk;

  // Gate models: instance 0 selectable, instance 1 OR, instance 2 AND.
  always_comb begin
    case (mode)
      0:       y_v[0] = a_v[0] & b_v[0];
      1:       y_v[0] = 1'b0;
      2:       y_v[0] = 1'b1;
      3:       y_v[0] = a_v[0] | b_v[0];
      4:       y_v[0] = a_v[0] ^ b_v[0];
      default: y_v[0] = ~(a_v[0] & b_v[0]);
    endcase
    y_v[1] = a_v[1] | b_v[1];
    y_v[2] = a_v[2] & b_v[2];
  end

  gate_tester u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
    .y_in(y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_mask(mask_v[0]), .vec_idx(idx_v[0])
  );

  gate_tester #(.EXPECT_TT(4'b1110)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
    .y_in(y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_mask(mask_v[1]), .vec_idx(idx_v[1])
  );

  gate_tester #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
    .y_in(y_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .fail_mask(mask_v[2]), .vec_idx(idx_v[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One run on instance sel with settle window s; optional start re-pulses in cycles 3 and 8.
  task automatic run(input int sel, input int s, input bit repulse);
    exp_t e;
    bit   found = 1'b0;
    int   k;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_v[sel] = repulse && (c == 3 || c == 8);
      if (c <= 4 * (s + 1)) begin
        k = (c - 1) / (s + 1);
        chk("vec_idx", int'(idx_v[sel]), k);
        chk("ab_out", int'({a_v[sel], b_v[sel]}), k);
      end
      if (c == 1) chk("busy_first", int'(busy_v[sel]), 1);
      if (done_v[sel]) begin
        e = sb.pop_front();
        chk("done_cycle", c, e.cyc);
        chk("fail_mask", int'(mask_v[sel]), int'(e.mask));
        chk("pass", int'(pass_v[sel]), int'(e.pass));
        chk("busy_in_done", int'(busy_v[sel]), 1);
        found = 1'b1;
        break;
      end
    end
    start_v[sel] = 1'b0;
    if (!found) chk("done_timeout", 0, 1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("no_extra_done", int'(done_v[sel]), 0);
    end
    chk("busy_after", int'(busy_v[sel]), 0);
  endtask

  initial begin
    tbl[0] = '{0, 4'b0000, 1'b1};
    tbl[1] = '{1, 4'b1000, 1'b0};
    tbl[2] = '{2, 4'b0111, 1'b0};
    tbl[3] = '{3, 4'b0110, 1'b0};
    tbl[4] = '{4, 4'b1110, 1'b0};
    tbl[5] = '{5, 4'b1111, 1'b0};

    rst = 1'b1; start_v = '0; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_pass", int'(pass_v[0]), 0);
    chk("rst_mask", int'(mask_v[0]), 0);
    chk("rst_idx", int'(idx_v[0]), 0);
    rst = 1'b0;

    // Truth-table table on the default instance.
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      sb.push_back('{tbl[i].mask, tbl[i].pass, 13});
      run(0, 2, 1'b0);
    end

    // start re-pulsed mid-run is ignored.
    mode = 0;
    sb.push_back('{4'b0000, 1'b1, 13});
    run(0, 2, 1'b1);

    // OR gate against an OR expectation.
    sb.push_back('{4'b0000, 1'b1, 13});
    run(1, 2, 1'b0);

    // Reset in cycle 5 of a failing run.
    mode = 5;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_mask", int'(mask_v[0]), 0);
    chk("midrst_idx", int'(idx_v[0]), 0);
    chk("midrst_ab", int'({a_v[0], b_v[0]}), 0);
    chk("midrst_done", int'(done_v[0]), 0);
    chk("midrst_pass", int'(pass_v[0]), 0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_idle", int'(busy_v[0]), 0);
    end
    mode = 0;
    sb.push_back('{4'b0000, 1'b1, 13});
    run(0, 2, 1'b0);

    // Single-cycle settle with start held high: done in cycles 9, 19, 29.
    @(negedge clk);
    start_v[2] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      int o;
      @(negedge clk);
      o = (c - 1) % 10;
      if (o < 8) chk("held_vec", int'(idx_v[2]), o / 2);
      chk("held_done", int'(done_v[2]), (c == 9 || c == 19 || c == 29) ? 1 : 0);
      if (done_v[2]) chk("held_pass", int'(pass_v[2]), 1);
      if (c == 29) start_v[2] = 1'b0;
    end
    repeat (12) begin
      @(negedge clk);
      chk("held_stop", int'(done_v[2]), 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
